// File: rtl/acc_sched_pkg.sv
// Shared definitions for the accumulator command scheduler:
// command encoding and scheduler FSM state type.
package acc_sched_pkg;

    localparam int unsigned CMD_W = 3;

    // Codes 6 and 7 are reserved and behave as READ.
    typedef enum logic [CMD_W-1:0] {
        CMD_READ = 3'd0,
        CMD_CLR  = 3'd1,
        CMD_SET  = 3'd2,
        CMD_LOAD = 3'd3,
        CMD_ADD  = 3'd4,
        CMD_INC  = 3'd5,
        CMD_RSV6 = 3'd6,
        CMD_RSV7 = 3'd7
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/acc_sched_rr_arbiter.sv
// Round-robin arbiter for acc_sched.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   req            : per-requester request vector
//   upd            : when high and a request is present, pointer moves to the winner
//   grant_c        : one-hot grant (combinational)
//   idx_c          : index of the granted requester (combinational)
//   any_c          : at least one request present (combinational)
module rr_arbiter #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = $clog2(NREQ)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [NREQ-1:0] req,
    input  logic            upd,
    output logic [NREQ-1:0] grant_c,
    output logic [IW-1:0]   idx_c,
    output logic            any_c
);

    logic [IW-1:0] ptr;

    // Last granted index; resets to NREQ-1 so requester 0 wins first.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ptr <= IW'(NREQ - 1);
        end else if (upd && any_c) begin
            ptr <= idx_c;
        end
    end

    // Search starts one past the last grant and wraps around.
    always_comb begin
        int unsigned   k;
        logic [IW-1:0] kidx;
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        k       = 0;
        kidx    = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            k = 32'(ptr) + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            kidx = IW'(k);
            if (!any_c && req[kidx]) begin
                any_c         = 1'b1;
                idx_c         = kidx;
                grant_c[kidx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/acc_sched.sv
// Accumulator command scheduler: arbitrates NREQ requesters round-robin,
// issues one command at a time to an external accumulator and returns its
// post-command value.
// Ports:
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_req/i_cmd/i_data    : per-requester request, 3-bit command, W-bit operand
//   o_ack                 : one-hot accept pulse
//   o_rvalid/o_rid/o_result : result pulse, owning requester, accumulator value
//   o_acc_*               : accumulator strobes and operand
//   i_acc                 : accumulator readback
module acc_sched
    import acc_sched_pkg::*;
#(
    parameter  int unsigned W    = 16,
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = $clog2(NREQ)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NREQ-1:0]      i_req,
    input  logic [CMD_W*NREQ-1:0] i_cmd,
    input  logic [W*NREQ-1:0]    i_data,
    output logic [NREQ-1:0]      o_ack,
    output logic                 o_rvalid,
    output logic [IW-1:0]        o_rid,
    output logic [W-1:0]         o_result,
    output logic                 o_acc_reset,
    output logic                 o_acc_set,
    output logic                 o_acc_load,
    output logic                 o_acc_add,
    output logic                 o_acc_inc,
    output logic [W-1:0]         o_acc_val,
    input  logic [W-1:0]         i_acc
);

    state_e            state;
    logic [IW-1:0]     win_q;
    logic [NREQ-1:0]   arb_grant;
    logic [IW-1:0]     arb_idx;
    logic              arb_any;
    logic              arb_upd;
    logic [CMD_W-1:0]  sel_cmd;
    logic [W-1:0]      sel_data;

    assign arb_upd = (state == ST_IDLE);

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .req     (i_req),
        .upd     (arb_upd),
        .grant_c (arb_grant),
        .idx_c   (arb_idx),
        .any_c   (arb_any)
    );

    // Command/operand mux for the arbitration winner.
    always_comb begin
        sel_cmd  = '0;
        sel_data = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (arb_idx == IW'(k)) begin
                sel_cmd  = i_cmd[k*CMD_W +: CMD_W];
                sel_data = i_data[k*W +: W];
            end
        end
    end

    // Outputs are registered on entry to the state in which they are
    // visible, so o_ack shows during ISSUE and o_rvalid during RESP.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            win_q       <= '0;
            o_ack       <= '0;
            o_rvalid    <= 1'b0;
            o_rid       <= '0;
            o_result    <= '0;
            o_acc_val   <= '0;
            o_acc_reset <= 1'b1;
            o_acc_set   <= 1'b0;
            o_acc_load  <= 1'b0;
            o_acc_add   <= 1'b0;
            o_acc_inc   <= 1'b0;
        end else begin
            o_ack       <= '0;
            o_rvalid    <= 1'b0;
            o_acc_reset <= 1'b0;
            o_acc_set   <= 1'b0;
            o_acc_load  <= 1'b0;
            o_acc_add   <= 1'b0;
            o_acc_inc   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        win_q     <= arb_idx;
                        o_ack     <= arb_grant;
                        o_acc_val <= sel_data;
                        case (cmd_e'(sel_cmd))
                            CMD_CLR:  o_acc_reset <= 1'b1;
                            CMD_SET:  o_acc_set   <= 1'b1;
                            CMD_LOAD: o_acc_load  <= 1'b1;
                            CMD_ADD:  o_acc_add   <= 1'b1;
                            CMD_INC:  o_acc_inc   <= 1'b1;
                            default:  ;
                        endcase
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    // Accumulator has absorbed the strobe by now.
                    o_rvalid <= 1'b1;
                    o_rid    <= win_q;
                    o_result <= i_acc;
                    state    <= ST_RESP;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/acc_sched.md
ACC_SCHED -- requirements
Module: acc_sched

Interface
REQ-001 Parameter W, default 16, accumulator and data width in bits.
REQ-002 Parameter NREQ, default 4, number of requesters (2..8).
REQ-003 i_clk  input  1  clock; all state changes on rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_req  input  NREQ  per-requester request, held until matching o_ack.
REQ-006 i_cmd  input  3*NREQ  per-requester command, requester k in bits [3k+2:3k].
REQ-007 i_data  input  W*NREQ  per-requester operand, requester k in bits [Wk+W-1:Wk].
REQ-008 o_ack  output  NREQ  one-hot accept pulse, one cycle.
REQ-009 o_rvalid  output  1  result-valid pulse, one cycle.
REQ-010 o_rid  output  clog2(NREQ)  requester index owning o_result.
REQ-011 o_result  output  W  accumulator value after the accepted command.
REQ-012 o_acc_reset, o_acc_set, o_acc_load, o_acc_add, o_acc_inc  output  1 each  accumulator strobes, registered.
REQ-013 o_acc_val  output  W  accumulator operand, registered.
REQ-014 i_acc  input  W  accumulator register readback.

Function
REQ-015 Commands: 0 READ, 1 CLR, 2 SET, 3 LOAD, 4 ADD, 5 INC; 6 and 7 SHALL execute as READ.
REQ-016 FSM states IDLE, ISSUE, WAIT, RESP; one command in flight at a time.
REQ-017 IDLE: any i_req high -> latch winner index, its cmd and data -> ISSUE next cycle; else stay IDLE.
REQ-018 Winner SHALL be round-robin: search starts at last granted index +1, modulo NREQ.
REQ-019 ISSUE (one cycle): o_ack[winner]=1; exactly one strobe per decoded command (none for READ); o_acc_val = latched data -> WAIT.
REQ-020 WAIT (one cycle): all strobes 0; i_acc now holds post-command value -> RESP.
REQ-021 RESP (one cycle): o_rvalid=1, o_rid=winner, o_result=i_acc sampled at end of WAIT -> IDLE.
REQ-022 Latency: i_req seen in cycle t -> o_ack in t+1 -> o_rvalid in t+3; peak throughput one command per 4 cycles.
REQ-023 Request dropped before ack SHALL not be granted; request present only during ISSUE/WAIT/RESP waits for next IDLE.
REQ-024 o_acc_val SHALL be held between commands; strobes SHALL never overlap.
REQ-025 Arithmetic wrap (ADD/INC overflow, SET = all ones) is the accumulator's; o_result reports the wrapped value unchanged.
REQ-026 o_ack, o_rvalid zero outside ISSUE and RESP respectively.

Reset
REQ-027 i_reset in any state SHALL return FSM to IDLE next edge, discarding any in-flight command without o_ack or o_rvalid.
REQ-028 Reset values: o_acc_reset=1 (clears accumulator the following cycle), all other strobes 0, o_ack 0, o_rvalid 0, o_rid 0, o_result 0, o_acc_val 0, round-robin pointer NREQ-1 (requester 0 highest priority first).
REQ-029 o_acc_reset SHALL drop to 0 in the first cycle after i_reset deasserts, except when pulsed by CLR.

Structure
REQ-030 Package acc_sched_pkg SHALL hold the command encoding and FSM state type.
REQ-031 Round-robin selection SHALL be sub-module rr_arbiter (NREQ request in, one-hot grant and index out, pointer update input).
REQ-032 No other sub-modules; accumulator instantiated outside this block.

Verification
REQ-033 W=16: reset, then req0 LOAD 0x1234 -> o_ack[0] at t+1, o_acc_load pulse, o_rvalid at t+3 with rid=0, result 0x1234.
REQ-034 req0 INC, req1 ADD 0x0010, req2 SET simultaneously from 0x1234 -> grants 0,1,2 in order, results 0x1235, 0x1245, 0xFFFF.
REQ-035 Accumulator 0xFFFF, req3 INC -> result 0x0000; next req3 CLR -> o_acc_reset pulse, result 0x0000.
REQ-036 All four requesters held high for 16 commands -> grants strictly 0,1,2,3 repeating, each 4 cycles apart.
REQ-037 i_reset asserted in WAIT of an ADD -> no o_rvalid, FSM IDLE, o_acc_reset high one cycle, next grant to requester 0.
REQ-038 req1 cmd 7 with i_acc 0x00AB -> no strobe, o_result 0x00AB, rid=1.
